// File: rtl/vga_scanout_if.sv
// vga_scanout_if
//   Groups the video RAM read port and the video output signals that
//   vga_scanout drives.
//   master : used by vga_scanout (drives address and video outputs, reads RAM data)
//   slave  : used by the RAM/display side (drives RAM data, reads the rest)
//   Signals:
//     vram_address  14  read address to video RAM
//     vram_data      8  RAM data, valid one clock after vram_address is sampled
//     pixel          1  serial pixel, 1 = foreground
//     hsync          1  horizontal sync, active low
//     vsync          1  vertical sync, active low
//     video_active   1  pixel lies inside the visible area
//     vblank_irq     1  one-clock pulse at the start of the first blanked line
interface vga_scanout_if;
  logic [13:0] vram_address;
  logic [7:0]  vram_data;
  logic        pixel;
  logic        hsync;
  logic        vsync;
  logic        video_active;
  logic        vblank_irq;

  modport master (
    output vram_address,
    input  vram_data,
    output pixel,
    output hsync,
    output vsync,
    output video_active,
    output vblank_irq
  );

  modport slave (
    input  vram_address,
    output vram_data,
    input  pixel,
    input  hsync,
    input  vsync,
    input  video_active,
    input  vblank_irq
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout
//   Generates VGA timing from the pixel clock and serialises a 1bpp
//   framebuffer held in video RAM, doubled 2x horizontally and vertically.
//   Each fetched byte covers 16 screen pixels, MSB first; each source line
//   is shown on two consecutive screen lines.
//   Ports:
//     clock    in  pixel clock, rising edge
//     reset_n  in  asynchronous active-low reset
//     bus      vga_scanout_if.master (RAM read port and video outputs)
//   Pipeline: counter state -> stage 1 -> stage 2 -> registered outputs,
//   so every output is exactly 3 clocks behind the counters that define it.
//   H_VISIBLE is expected to be a multiple of 16.
module vga_scanout #(
  parameter int          H_VISIBLE      = 640,
  parameter int          H_FRONT        = 16,
  parameter int          H_SYNC         = 96,
  parameter int          H_BACK         = 48,
  parameter int          V_VISIBLE      = 480,
  parameter int          V_FRONT        = 10,
  parameter int          V_SYNC         = 2,
  parameter int          V_BACK         = 33,
  parameter logic [13:0] BASE_ADDRESS   = 14'h0000,
  parameter int          BYTES_PER_LINE = 40
) (
  input logic          clock,
  input logic          reset_n,
  vga_scanout_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] h_count, h_next;
  logic [VW-1:0] v_count, v_next;
  logic          fetch_next;
  logic [13:0]   fetch_addr;
  logic          active0, hsync0, vsync0, irq0;

  logic          act1, load1, even1, hs1, vs1, irq1;
  logic          act2, hs2, vs2, irq2;
  logic [7:0]    shreg;

  logic [13:0]   vram_address_q;
  logic          pixel_q, hsync_q, vsync_q, active_q, irq_q;

  always_comb begin
    h_next = (h_count == H_LAST) ? '0 : h_count + 1'b1;
    v_next = v_count;
    if (h_count == H_LAST) begin
      v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end
    // Address of byte k must be on the bus while the counter sits at x=16k,
    // so it is registered on the edge that moves the counter there.
    fetch_next = (h_next < H_VIS) && (v_next < V_VIS) && (h_next[3:0] == 4'd0);
    fetch_addr = BASE_ADDRESS + 14'(v_next >> 1) * 14'(BYTES_PER_LINE) + 14'(h_next >> 4);

    active0 = (h_count < H_VIS) && (v_count < V_VIS);
    hsync0  = !((h_count >= HS_START) && (h_count <= HS_END));
    vsync0  = !((v_count >= VS_START) && (v_count <= VS_END));
    irq0    = (h_count == '0) && (v_count == V_VIS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count        <= '0;
      v_count        <= '0;
      vram_address_q <= BASE_ADDRESS;
      act1           <= 1'b0;
      load1          <= 1'b0;
      even1          <= 1'b0;
      hs1            <= 1'b1;
      vs1            <= 1'b1;
      irq1           <= 1'b0;
      act2           <= 1'b0;
      hs2            <= 1'b1;
      vs2            <= 1'b1;
      irq2           <= 1'b0;
      shreg          <= 8'h00;
      pixel_q        <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      active_q       <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      if (fetch_next) begin
        vram_address_q <= fetch_addr;
      end

      act1  <= active0;
      load1 <= active0 && (h_count[3:0] == 4'd0);
      even1 <= !h_count[0];
      hs1   <= hsync0;
      vs1   <= vsync0;
      irq1  <= irq0;

      // RAM data for byte k is valid while stage 1 holds x=16k; it then feeds
      // the pixel stage from x=16k onward, shifting after each odd pixel.
      if (load1) begin
        shreg <= bus.vram_data;
      end else if (act1 && even1) begin
        shreg <= {shreg[6:0], 1'b0};
      end

      act2 <= act1;
      hs2  <= hs1;
      vs2  <= vs1;
      irq2 <= irq1;

      pixel_q  <= act2 && shreg[7];
      active_q <= act2;
      hsync_q  <= hs2;
      vsync_q  <= vs2;
      irq_q    <= irq2;
    end
  end

  assign bus.vram_address = vram_address_q;
  assign bus.pixel        = pixel_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.video_active = active_q;
  assign bus.vblank_irq   = irq_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Bench for vga_scanout using a reduced display geometry so whole frames
//   fit in a short run. A behavioural model derives every expected output from
//   the cycle count since reset release and the VRAM contents; expectations are
//   queued at each rising edge and a monitor compares them on the falling edge.
module tb_vga_scanout;
  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 16, VF = 2, VS = 2, VB = 3;
  localparam int BPL = 4;
  localparam logic [13:0] BASE = 14'h3FF8;  // fetches wrap past the top of VRAM
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic pixel;
    logic hsync;
    logic vsync;
    logic active;
    logic irq;
  } out_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  vga_scanout_if bus ();

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .BASE_ADDRESS(BASE), .BYTES_PER_LINE(BPL)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [16384];
  always @(posedge clock) bus.vram_data <= mem[bus.vram_address];

  out_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   irq_seen = 0;
  bit   sb_en = 1'b0;

  // Expected outputs during cycle c after release: the pipeline shows reset
  // values for three clocks, then the state of scan position c-3.
  function automatic out_t model(int c);
    out_t o;
    int n, h, v;
    logic [13:0] a;
    logic [7:0] b;
    o = '{pixel: 1'b0, hsync: 1'b1, vsync: 1'b1, active: 1'b0, irq: 1'b0};
    if (c >= 3) begin
      n = c - 3;
      h = n % HT;
      v = (n / HT) % VT;
      o.active = (h < HV) && (v < VV);
      o.hsync  = !(h >= HV + HF && h < HV + HF + HS);
      o.vsync  = !(v >= VV + VF && v < VV + VF + VS);
      o.irq    = (h == 0) && (v == VV);
      a = BASE + 14'((v / 2) * BPL + h / 16);
      b = mem[a];
      o.pixel = o.active && b[7 - ((h / 2) % 8)];
    end
    return o;
  endfunction

  always @(posedge clock) begin
    if (reset_n && sb_en) begin
      cyc = cyc + 1;
      exp_q.push_back(model(cyc));
    end
  end

  always @(negedge clock) begin
    out_t e, a;
    if (reset_n && sb_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{pixel: bus.pixel, hsync: bus.hsync, vsync: bus.vsync,
            active: bus.video_active, irq: bus.vblank_irq};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL scan cyc=%0d pix/hs/vs/act/irq got=%b required=%b", cyc, a, e);
      end
      if (bus.vblank_irq === 1'b1) irq_seen++;
    end
  end

  task automatic check_reset(input string name);
    logic [18:0] got, req;
    got = {bus.pixel, bus.hsync, bus.vsync, bus.video_active, bus.vblank_irq, bus.vram_address};
    req = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BASE};
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Drops reset between edges and checks that outputs follow without a clock.
  task automatic assert_reset(input string name);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    sb_en = 1'b0;
    exp_q.delete();
    #1;
    check_reset({name, "_async"});
  endtask

  task automatic release_reset(input string name, input int hold);
    repeat (hold) @(posedge clock);
    @(negedge clock);
    check_reset({name, "_held"});
    #1;
    cyc = 0;
    sb_en = 1'b1;
    reset_n = 1'b1;
  endtask

  task automatic check_count(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

    // Random contents, two full frames from reset.
    assert_reset("rst_init");
    release_reset("rst_init", 5);
    repeat (2 * FRAME + 50) @(posedge clock);

    // Byte 0 = A5, byte 1 = FF on the first source line.
    assert_reset("rst_a5");
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[BASE] = 8'hA5;
    mem[14'(BASE + 14'd1)] = 8'hFF;
    release_reset("rst_a5", 5);
    repeat (HT * 6) @(posedge clock);

    // Line doubling and stride: second source line starts with 80.
    assert_reset("rst_stride");
    mem[BASE] = 8'h00;
    mem[14'(BASE + 14'd1)] = 8'h00;
    mem[14'(BASE + 14'(BPL))] = 8'h80;
    release_reset("rst_stride", 5);
    repeat (HT * 6) @(posedge clock);

    // All ones: pixel follows video_active, one vblank pulse per frame.
    assert_reset("rst_ones");
    for (int i = 0; i < 16384; i++) mem[i] = 8'hFF;
    release_reset("rst_ones", 5);
    irq_seen = 0;
    repeat (2 * FRAME) @(posedge clock);
    @(negedge clock);
    check_count("vblank_per_2_frames", irq_seen, 2);

    // Random contents again, reset dropped mid-line, then restart.
    assert_reset("rst_pre_mid");
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    release_reset("rst_pre_mid", 3);
    repeat (10 * HT + 30) @(posedge clock);
    assert_reset("rst_mid");
    release_reset("rst_mid", 4);
    irq_seen = 0;
    repeat (2 * FRAME + 20) @(posedge clock);
    @(negedge clock);
    check_count("vblank_after_mid_reset", irq_seen, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
